// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one registered fp16 adder between NREQ requesters,
// with a credit-guarded result FIFO. Define FPADD_ARB_STATS_EN for issue/stall counters.
module fp_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int LAT   = 1,
  parameter int DEPTH = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [15:0]        add_a,
  output logic [15:0]        add_b,
  input  logic [15:0]        add_sum,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [15:0]        rsp_sum,
  input  logic [NREQ-1:0]    rsp_ready
`ifdef FPADD_ARB_STATS_EN
  ,
  output logic [15:0]        issue_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   add_a_q, add_b_q;
  logic [LAT:0]  tag_v_q;
  logic [IW-1:0] tag_id_q [0:LAT];
  logic [15:0]   mem_sum_q [0:DEPTH-1];
  logic [IW-1:0] mem_id_q [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   rsp_sum_q;

  logic          credit_ok;
  logic          hs;
  logic [IW-1:0] gnt_idx;
  logic [NREQ-1:0] grant;
  logic          push, pop, empty;
  logic [IW-1:0] head_id;

  // Credits count both queued results and adds still in the tag pipe, so the
  // non-stallable adder can never push into a full FIFO.
  always_comb begin : arb
    int tmp;
    logic [IW-1:0] idx;
    tmp       = 0;
    idx       = '0;
    grant     = '0;
    hs        = 1'b0;
    gnt_idx   = '0;
    credit_ok = (int'(cnt_q) + $countones(tag_v_q)) < DEPTH;
    if (credit_ok && !RESET) begin
      for (int k = 0; k < NREQ; k++) begin
        tmp = int'(ptr_q) + k;
        if (tmp >= NREQ) tmp = tmp - NREQ;
        idx = IW'(tmp);
        if (!hs && req_valid[idx]) begin
          hs         = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = idx;
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  assign empty   = (cnt_q == '0);
  assign head_id = mem_id_q[rd_ptr_q];
  assign push    = tag_v_q[LAT];
  assign pop     = !empty && rsp_ready[head_id];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      tag_v_q   <= '0;
      for (int k = 0; k <= LAT; k++) tag_id_q[k] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_sum_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (hs) begin
        add_a_q <= req_a[16*gnt_idx +: 16];
        add_b_q <= req_b[16*gnt_idx +: 16];
      end
      tag_v_q     <= {tag_v_q[LAT-1:0], hs};
      tag_id_q[0] <= gnt_idx;
      for (int k = 1; k <= LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (!empty) rsp_sum_q <= mem_sum_q[rd_ptr_q];
    end
  end

  // Storage needs no reset: entries are only visible through the counted range.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_sum_q[wr_ptr_q] <= add_sum;
      mem_id_q[wr_ptr_q]  <= tag_id_q[LAT];
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = empty ? '0 : (NREQ'(1) << head_id);
  assign rsp_sum   = empty ? rsp_sum_q : mem_sum_q[rd_ptr_q];

`ifdef FPADD_ARB_STATS_EN
  logic [15:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs) issue_cnt_q <= issue_cnt_q + 16'd1;
      if (|req_valid && !credit_ok) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter (NREQ=4, LAT=1, DEPTH=3)
// with a one-cycle registered fp16 adder model driven by a lookup of known sums.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   req_valid;
  logic [16*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       add_a, add_b;
  logic [15:0]       add_sum = 16'h0000;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_sum;
  logic [NREQ-1:0]   rsp_ready;
`ifdef FPADD_ARB_STATS_EN
  logic [15:0]       issue_cnt, stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [3:0]  RR_GNT [12] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h8, 4'h1,
                                          4'h2, 4'h0, 4'h4, 4'h8, 4'h1, 4'h0};
  localparam logic [3:0]  RR_RSP [12] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4,
                                          4'h0, 4'h8, 4'h1, 4'h2, 4'h0, 4'h4};
  localparam logic [15:0] RR_SUM [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h4000,
                                          16'h4400, 16'h4600, 16'h4600, 16'h4800,
                                          16'h4000, 16'h4400, 16'h4400, 16'h4600};

  fp_add_arbiter #(.NREQ(4), .LAT(1), .DEPTH(3)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
`ifdef FPADD_ARB_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] fpadd(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4200;
      32'h3800_3800: return 16'h3C00;
      32'h3C00_3C00: return 16'h4000;
      32'h4000_4000: return 16'h4400;
      32'h4200_4200: return 16'h4600;
      32'h4400_4400: return 16'h4800;
      32'h0000_0000: return 16'h0000;
      default:       return 16'hFFFF;
    endcase
  endfunction

  always @(posedge CLK) add_sum <= fpadd(add_a, add_b);

  task automatic do_reset();
    RESET     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    @(negedge CLK); #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    tests_run++;
    if (add_a !== 16'h0 || add_b !== 16'h0) begin
      tests_failed++; $display("FAIL reset_add got %h/%h want 0000/0000", add_a, add_b);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000 || rsp_sum !== 16'h0) begin
      tests_failed++; $display("FAIL reset_rsp got %b/%h want 0000/0000", rsp_valid, rsp_sum);
    end
    req_valid = '0;
    RESET = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = '1;
    @(negedge CLK);
    req_valid = 4'b0001; req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000; #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL single_grant got %b want 0001", req_ready);
    end
    @(negedge CLK); req_valid = '0; #1;
    tests_run++;
    if (add_a !== 16'h3C00 || add_b !== 16'h4000) begin
      tests_failed++; $display("FAIL single_operands got %h/%h want 3c00/4000", add_a, add_b);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++; $display("FAIL single_early_t1 got %b want 0000", rsp_valid);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++; $display("FAIL single_early_t2 got %b want 0000", rsp_valid);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (rsp_valid !== 4'b0001 || rsp_sum !== 16'h4200) begin
      tests_failed++; $display("FAIL single_rsp got %b/%h want 0001/4200", rsp_valid, rsp_sum);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (rsp_valid !== 4'b0000 || rsp_sum !== 16'h4200 || add_a !== 16'h3C00) begin
      tests_failed++;
      $display("FAIL single_hold got %b/%h add_a %h want 0000/4200 add_a 3c00", rsp_valid, rsp_sum, add_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_a = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    req_b = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    rsp_ready = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK); req_valid = 4'b1111; #1;
      tests_run++;
      if (req_ready !== RR_GNT[c]) begin
        tests_failed++; $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, RR_GNT[c]);
      end
      tests_run++;
      if (rsp_valid !== RR_RSP[c] || rsp_sum !== RR_SUM[c]) begin
        tests_failed++;
        $display("FAIL rr_rsp cycle %0d got %b/%h want %b/%h", c, rsp_valid, rsp_sum, RR_RSP[c], RR_SUM[c]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int hs_cnt;
    int pops;
    do_reset();
    req_a[31:16] = 16'h3800; req_b[31:16] = 16'h3800;
    rsp_ready = '0;
    hs_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); req_valid = 4'b0010; #1;
      if (req_ready == 4'b0010) hs_cnt++;
    end
    tests_run++;
    if (hs_cnt !== 3) begin
      tests_failed++; $display("FAIL bp_handshakes got %0d want 3", hs_cnt);
    end
    @(negedge CLK); rsp_ready = 4'b0010; #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL bp_full_ready got %b want 0000", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 4'b0010 || rsp_sum !== 16'h3C00) begin
      tests_failed++; $display("FAIL bp_head got %b/%h want 0010/3c00", rsp_valid, rsp_sum);
    end
`ifdef FPADD_ARB_STATS_EN
    tests_run++;
    if (issue_cnt !== 16'd3 || stall_cnt !== 16'd7) begin
      tests_failed++; $display("FAIL stats got issue %0d stall %0d want 3/7", issue_cnt, stall_cnt);
    end
`endif
    @(negedge CLK); rsp_ready = '0; #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL bp_regrant got %b want 0010", req_ready);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL bp_single_regrant got %b want 0000", req_ready);
    end
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK); req_valid = '0; rsp_ready = '1; #1;
      if (rsp_valid == 4'b0010 && rsp_sum == 16'h3C00) pops++;
    end
    tests_run++;
    if (pops !== 3) begin
      tests_failed++; $display("FAIL bp_drain got %0d responses want 3", pops);
    end
  endtask

  task automatic test_wrong_owner();
    do_reset();
    req_a[47:32] = 16'h4200; req_b[47:32] = 16'h4200;
    rsp_ready = 4'b0001;
    @(negedge CLK); req_valid = 4'b0100; #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL wo_grant got %b want 0100", req_ready);
    end
    @(negedge CLK); req_valid = '0;
    @(negedge CLK);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      tests_run++;
      if (rsp_valid !== 4'b0100 || rsp_sum !== 16'h4600) begin
        tests_failed++; $display("FAIL wo_hold cycle %0d got %b/%h want 0100/4600", c, rsp_valid, rsp_sum);
      end
    end
    @(negedge CLK); rsp_ready = 4'b0100;
    @(negedge CLK); #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++; $display("FAIL wo_pop got %b want 0000", rsp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000;
    req_a[63:48] = 16'h4000; req_b[63:48] = 16'h4000;
    rsp_ready = '1;
    @(negedge CLK); req_valid = 4'b0001;
    @(negedge CLK); req_valid = '0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK); req_valid = 4'b1000; #1;
    tests_run++;
    if (req_ready !== 4'b1000 || rsp_sum !== 16'h4200) begin
      tests_failed++; $display("FAIL rst_pre got %b/%h want 1000/4200", req_ready, rsp_sum);
    end
    @(negedge CLK); req_valid = 4'b0001; #1;
    tests_run++;
    if (add_a !== 16'h4000) begin
      tests_failed++; $display("FAIL rst_issue got %h want 4000", add_a);
    end
    RESET = 1'b1; #1;
    tests_run++;
    if (req_ready !== 4'b0 || add_a !== 16'h0 || add_b !== 16'h0 ||
        rsp_valid !== 4'b0 || rsp_sum !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_mid got rdy %b a %h b %h rv %b rs %h want all 0",
               req_ready, add_a, add_b, rsp_valid, rsp_sum);
    end
    @(negedge CLK);
    @(negedge CLK); RESET = 1'b0; req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK); #1;
      tests_run++;
      if (rsp_valid !== 4'b0000) begin
        tests_failed++; $display("FAIL rst_no_rsp cycle %0d got %b want 0000", c, rsp_valid);
      end
    end
    @(negedge CLK); req_valid = 4'b1111; #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL rst_ptr got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrong_owner();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
